// File: rtl/nn_pkg.sv
// Shared constants and types for the nn parameter-dump path.
package nn_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_PARAMS = 18;

    localparam logic [15:0] FRAME_MAGIC = 16'hA55A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    // Word positions on the flat parameter bus
    localparam int unsigned IDX_W3_11 = 0;
    localparam int unsigned IDX_W3_12 = 1;
    localparam int unsigned IDX_W3_21 = 2;
    localparam int unsigned IDX_W3_22 = 3;
    localparam int unsigned IDX_W3_31 = 4;
    localparam int unsigned IDX_W3_32 = 5;
    localparam int unsigned IDX_W2_11 = 6;
    localparam int unsigned IDX_W2_12 = 7;
    localparam int unsigned IDX_W2_13 = 8;
    localparam int unsigned IDX_W2_21 = 9;
    localparam int unsigned IDX_W2_22 = 10;
    localparam int unsigned IDX_W2_23 = 11;
    localparam int unsigned IDX_B3_1  = 12;
    localparam int unsigned IDX_B3_2  = 13;
    localparam int unsigned IDX_B3_3  = 14;
    localparam int unsigned IDX_B2_1  = 15;
    localparam int unsigned IDX_B2_2  = 16;
    localparam int unsigned IDX_B2_3  = 17;

endpackage

// File: rtl/nn_param_dump_if.sv
// Framed word stream: valid/ready handshake with index and last marker.
interface nn_param_dump_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] dout;
    logic [7:0]        dout_idx;
    logic              dout_valid;
    logic              dout_last;
    logic              dout_ready;

    modport master (
        output dout, dout_idx, dout_valid, dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout, dout_idx, dout_valid, dout_last,
        output dout_ready
    );
endinterface

// File: rtl/nn_auto_tick.sv
// Free-running period counter; o_tick_c is high in the cycle the count hits AUTO_PERIOD-1.
module nn_auto_tick #(
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic clk,
    input  logic res,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int unsigned LAST  = (AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0;
    localparam bit          EN    = (AUTO_PERIOD != 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == CNT_W'(LAST));
    assign o_tick_c = EN && w_wrap;

    // Counter parks at zero when the period is 0
    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
        end else if (!EN || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nn_param_dump.sv
// Snapshot all parameter words in one cycle and stream them as header, data words, checksum.
module nn_param_dump #(
    parameter int unsigned NUM_WORDS   = nn_pkg::NUM_PARAMS,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        snap,
    input  logic [NUM_WORDS*WORD_W-1:0] param_in,
    nn_param_dump_if.master             strm,
    output logic                        busy,
    output logic                        snap_dropped
);

    import nn_pkg::*;

    localparam int unsigned PTR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_e            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_dout;
    logic [7:0]        r_seq;
    logic [7:0]        r_idx;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_dropped;
    logic [WORD_W-1:0] r_shadow [NUM_WORDS];

    logic              w_tick;
    logic              w_req;
    logic              w_hs;
    logic              w_accept;
    logic              w_ptr_end;
    logic [WORD_W-1:0] w_sum;
    logic [WORD_W-1:0] w_hdr;

    nn_auto_tick #(
        .AUTO_PERIOD (AUTO_PERIOD)
    ) u_auto_tick (
        .clk      (clk),
        .res      (res),
        .o_tick_c (w_tick)
    );

    assign w_req     = snap | w_tick;
    assign w_hs      = r_valid & strm.dout_ready;
    assign w_accept  = (r_state == ST_IDLE) & w_req;
    assign w_ptr_end = (r_ptr == PTR_W'(NUM_WORDS - 1));
    assign w_sum     = r_acc + r_dout;
    assign w_hdr     = WORD_W'({FRAME_MAGIC, 8'(NUM_WORDS), r_seq});

    assign strm.dout       = r_dout;
    assign strm.dout_idx   = r_idx;
    assign strm.dout_valid = r_valid;
    assign strm.dout_last  = r_last;
    assign busy            = r_busy;
    assign snap_dropped    = r_dropped;

    // Shadow copy: only written on an accepted request, so the frame in flight is frozen
    always_ff @(posedge clk) begin
        if (!res && w_accept) begin
            for (int k = 0; k < int'(NUM_WORDS); k++) begin
                r_shadow[k] <= param_in[k*WORD_W +: WORD_W];
            end
        end
    end

    // Framer FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_acc     <= '0;
            r_dout    <= '0;
            r_seq     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_req && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_HDR;
                        r_dout  <= w_hdr;
                        r_idx   <= 8'd0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (w_hs) begin
                        r_state <= ST_DATA;
                        r_acc   <= r_dout;
                        r_ptr   <= '0;
                        r_dout  <= r_shadow[0];
                        r_idx   <= 8'd1;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        r_acc <= w_sum;
                        if (w_ptr_end) begin
                            r_state <= ST_CSUM;
                            r_dout  <= w_sum;
                            r_idx   <= 8'(NUM_WORDS + 1);
                            r_last  <= 1'b1;
                        end else begin
                            r_ptr  <= r_ptr + PTR_W'(1);
                            r_dout <= r_shadow[r_ptr + PTR_W'(1)];
                            r_idx  <= 8'(r_ptr) + 8'd2;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_hs) begin
                        r_state <= ST_IDLE;
                        r_seq   <= r_seq + 8'd1;
                        r_dout  <= '0;
                        r_idx   <= 8'd0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_param_dump.sv
// Self-checking bench for nn_param_dump: scoreboard of expected frame words.
module tb_nn_param_dump;
    import nn_pkg::*;

    localparam int unsigned NW = NUM_PARAMS;
    localparam int unsigned WW = 32;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               res;
    logic               snap;
    logic               a_res;
    logic               a_snap;
    logic [NW*WW-1:0]   param_in;
    logic               busy;
    logic               snap_dropped;
    logic               a_busy;
    logic               a_dropped;

    nn_param_dump_if #(.WORD_W(WW)) s_if ();
    nn_param_dump_if #(.WORD_W(WW)) a_if ();

    nn_param_dump #(.NUM_WORDS(NW), .WORD_W(WW), .AUTO_PERIOD(0)) dut (
        .clk          (clk),
        .res          (res),
        .snap         (snap),
        .param_in     (param_in),
        .strm         (s_if),
        .busy         (busy),
        .snap_dropped (snap_dropped)
    );

    nn_param_dump #(.NUM_WORDS(NW), .WORD_W(WW), .AUTO_PERIOD(30)) dut_auto (
        .clk          (clk),
        .res          (a_res),
        .snap         (a_snap),
        .param_in     (param_in),
        .strm         (a_if),
        .busy         (a_busy),
        .snap_dropped (a_dropped)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    task automatic set_params(input logic [31:0] base);
        int unsigned ord [NUM_PARAMS] = '{IDX_W3_11, IDX_W3_12, IDX_W3_21, IDX_W3_22,
                                          IDX_W3_31, IDX_W3_32, IDX_W2_11, IDX_W2_12,
                                          IDX_W2_13, IDX_W2_21, IDX_W2_22, IDX_W2_23,
                                          IDX_B3_1, IDX_B3_2, IDX_B3_3,
                                          IDX_B2_1, IDX_B2_2, IDX_B2_3};
        for (int j = 0; j < int'(NW); j++) begin
            param_in[ord[j]*WW +: WW] = base + 32'(ord[j]);
        end
    endtask

    // Expected frame from the current param_in contents
    task automatic push_frame(input logic [7:0] seq);
        exp_t        e;
        logic [31:0] sum;
        e.d = {FRAME_MAGIC, 8'(NW), seq};
        e.idx = 8'd0;
        e.last = 1'b0;
        q.push_back(e);
        sum = e.d;
        for (int k = 0; k < int'(NW); k++) begin
            e.d = param_in[k*WW +: WW];
            e.idx = 8'(k + 1);
            e.last = 1'b0;
            q.push_back(e);
            sum = sum + e.d;
        end
        e.d = sum;
        e.idx = 8'(NW + 1);
        e.last = 1'b1;
        q.push_back(e);
    endtask

    task automatic test_reset();
        res = 1'b1;
        snap = 1'b0;
        s_if.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (s_if.dout_valid !== 1'b0 || s_if.dout_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid_last got=%b%b exp=00", s_if.dout_valid, s_if.dout_last);
        end
        n_cmp++;
        if (s_if.dout !== 32'h0 || s_if.dout_idx !== 8'h0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%h exp=0/0", s_if.dout, s_if.dout_idx);
        end
        n_cmp++;
        if (busy !== 1'b0 || snap_dropped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status got=%b%b exp=00", busy, snap_dropped);
        end
        res = 1'b0;
        s_if.dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (s_if.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready_no_effect got=%b exp=0", s_if.dout_valid);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        q.delete();
        set_params(32'h0100_0000);
        s_if.dout_ready = 1'b1;
        snap = 1'b1;
        push_frame(8'd0);
        @(negedge clk);
        snap = 1'b0;
        for (int c = 0; c < int'(NW) + 2; c++) begin
            n_cmp++;
            if (s_if.dout_valid !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_valid cyc=%0d got=%b%b exp=11", c, s_if.dout_valid, busy);
            end
            if (s_if.dout_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (s_if.dout !== e.d || s_if.dout_idx !== e.idx || s_if.dout_last !== e.last) begin
                    n_err++;
                    $display("FAIL basic_word got=%h/%0d/%b exp=%h/%0d/%b",
                             s_if.dout, s_if.dout_idx, s_if.dout_last, e.d, e.idx, e.last);
                end
                if (e.last) begin
                    n_cmp++;
                    if (s_if.dout !== 32'hB75A_1299) begin
                        n_err++;
                        $display("FAIL basic_checksum got=%h exp=B75A1299", s_if.dout);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (s_if.dout_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end got=%b%b exp=00", s_if.dout_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic        stalled;
        logic [31:0] hd;
        logic [7:0]  hi;
        logic        hl;
        q.delete();
        s_if.dout_ready = 1'b0;
        snap = 1'b1;
        push_frame(8'd1);
        @(negedge clk);
        snap = 1'b0;
        stalled = 1'b0;
        hd = '0; hi = '0; hl = 1'b0;
        for (int c = 0; c < 200 && q.size() > 0; c++) begin
            if (stalled) begin
                n_cmp++;
                if (s_if.dout_valid !== 1'b1 || s_if.dout !== hd || s_if.dout_idx !== hi
                    || s_if.dout_last !== hl) begin
                    n_err++;
                    $display("FAIL bp_hold got=%b/%h/%0d exp=1/%h/%0d",
                             s_if.dout_valid, s_if.dout, s_if.dout_idx, hd, hi);
                end
            end
            s_if.dout_ready = (c % 4 == 0) || (c % 4 == 3);
            stalled = 1'b0;
            if (s_if.dout_valid === 1'b1) begin
                if (s_if.dout_ready) begin
                    e = q.pop_front();
                    n_cmp++;
                    if (s_if.dout !== e.d || s_if.dout_idx !== e.idx || s_if.dout_last !== e.last) begin
                        n_err++;
                        $display("FAIL bp_word got=%h/%0d/%b exp=%h/%0d/%b",
                                 s_if.dout, s_if.dout_idx, s_if.dout_last, e.d, e.idx, e.last);
                    end
                end else begin
                    stalled = 1'b1;
                    hd = s_if.dout;
                    hi = s_if.dout_idx;
                    hl = s_if.dout_last;
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL bp_timeout left=%0d exp=0", q.size());
        end
        n_cmp++;
        if (s_if.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end got=%b exp=0", s_if.dout_valid);
        end
        s_if.dout_ready = 1'b1;
    endtask

    task automatic test_isolation_drop();
        exp_t        e;
        int          drops;
        logic [31:0] hdr;
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        q.delete();
        set_params(32'h0200_0000);
        s_if.dout_ready = 1'b1;
        snap = 1'b1;
        push_frame(8'd0);
        @(negedge clk);
        snap = 1'b0;
        param_in = '1;
        drops = 0;
        for (int c = 0; c < int'(NW) + 2; c++) begin
            if (snap_dropped === 1'b1) drops++;
            snap = (s_if.dout_valid === 1'b1) && (s_if.dout_idx == 8'd5);
            if (s_if.dout_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (s_if.dout !== e.d || s_if.dout_idx !== e.idx || s_if.dout_last !== e.last) begin
                    n_err++;
                    $display("FAIL iso_word got=%h/%0d/%b exp=%h/%0d/%b",
                             s_if.dout, s_if.dout_idx, s_if.dout_last, e.d, e.idx, e.last);
                end
            end
            @(negedge clk);
        end
        snap = 1'b0;
        if (snap_dropped === 1'b1) drops++;
        n_cmp++;
        if (drops != 1) begin
            n_err++;
            $display("FAIL iso_drop_count got=%0d exp=1", drops);
        end
        n_cmp++;
        if (s_if.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL iso_end got=%b exp=0", s_if.dout_valid);
        end
        snap = 1'b1;
        hdr = {FRAME_MAGIC, 8'(NW), 8'd1};
        @(negedge clk);
        snap = 1'b0;
        n_cmp++;
        if (s_if.dout_valid !== 1'b1 || s_if.dout !== hdr) begin
            n_err++;
            $display("FAIL iso_next_seq got=%b/%h exp=1/%h", s_if.dout_valid, s_if.dout, hdr);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        for (int c = 0; c < 30; c++) begin
            if (s_if.dout_valid === 1'b1 && s_if.dout_idx == 8'd10) break;
            @(negedge clk);
        end
        n_cmp++;
        if (s_if.dout_valid !== 1'b1 || s_if.dout_idx !== 8'd10) begin
            n_err++;
            $display("FAIL rst_reach_idx10 got=%b/%0d exp=1/10", s_if.dout_valid, s_if.dout_idx);
        end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        n_cmp++;
        if (s_if.dout_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abandon got=%b%b exp=00", s_if.dout_valid, busy);
        end
        q.delete();
        set_params(32'h0300_0000);
        snap = 1'b1;
        push_frame(8'd0);
        @(negedge clk);
        snap = 1'b0;
        for (int c = 0; c < int'(NW) + 2; c++) begin
            n_cmp++;
            if (s_if.dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rst_frame_valid cyc=%0d got=%b exp=1", c, s_if.dout_valid);
            end
            if (s_if.dout_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (s_if.dout !== e.d || s_if.dout_idx !== e.idx || s_if.dout_last !== e.last) begin
                    n_err++;
                    $display("FAIL rst_word got=%h/%0d/%b exp=%h/%0d/%b",
                             s_if.dout, s_if.dout_idx, s_if.dout_last, e.d, e.idx, e.last);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_auto_wrap();
        exp_t e;
        logic exp_v;
        q.delete();
        set_params(32'h0400_0000);
        a_if.dout_ready = 1'b1;
        @(negedge clk);
        a_res = 1'b0;
        // Tick lands in cycle 29 after release; headers every 30 cycles from cycle 30
        for (int c = 1; c < 30 * 259; c++) begin
            @(negedge clk);
            if (c % 30 == 0) push_frame(8'((c / 30) - 1));
            exp_v = (c >= 30) && (c % 30 < int'(NW) + 2);
            n_cmp++;
            if (a_if.dout_valid !== exp_v || a_dropped !== 1'b0) begin
                n_err++;
                $display("FAIL auto_valid cyc=%0d got=%b/%b exp=%b/0", c, a_if.dout_valid, a_dropped, exp_v);
            end
            if (a_if.dout_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (a_if.dout !== e.d || a_if.dout_idx !== e.idx || a_if.dout_last !== e.last) begin
                    n_err++;
                    $display("FAIL auto_word cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", c,
                             a_if.dout, a_if.dout_idx, a_if.dout_last, e.d, e.idx, e.last);
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL auto_drain left=%0d exp=0", q.size());
        end
    endtask

    initial begin
        res = 1'b1;
        a_res = 1'b1;
        snap = 1'b0;
        a_snap = 1'b0;
        param_in = '0;
        s_if.dout_ready = 1'b0;
        a_if.dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation_drop();
        test_reset_midframe();
        test_auto_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
